// File: rtl/stage_retire_pkg.sv
// Shared types and sizing for the in-order commit stage (stage_retire).
// Optional feature macro: RETIRE_PERF_CNT_EN (adds retire performance counters).
package stage_retire_pkg;

  localparam int N             = 3;
  localparam int PHYS_TAG_BITS = 6;
  localparam int ARCH_REG_BITS = 5;
  localparam int CNT_W         = 64;
  localparam int RC_W          = $clog2(N + 1);
  localparam int LANE_W        = (N > 1) ? $clog2(N) : 1;

  typedef logic [PHYS_TAG_BITS-1:0] PHYS_TAG;

  typedef enum logic [3:0] {
    NO_ERROR            = 4'h0,
    INST_ADDR_MISALIGN  = 4'h1,
    INST_ACCESS_FAULT   = 4'h2,
    ILLEGAL_INST        = 4'h3,
    BREAKPOINT          = 4'h4,
    LOAD_ADDR_MISALIGN  = 4'h5,
    LOAD_ACCESS_FAULT   = 4'h6,
    STORE_ADDR_MISALIGN = 4'h7,
    STORE_ACCESS_FAULT  = 4'h8
  } EXCEPTION_CODE;

  typedef struct packed {
    logic                     valid;
    logic                     complete;
    logic [ARCH_REG_BITS-1:0] arch_rd;
    PHYS_TAG                  phys_rd;
    PHYS_TAG                  prev_phys_rd;
    EXCEPTION_CODE            exception;
    logic                     halt;
    logic                     branch;
  } ROB_ENTRY;

  typedef struct packed {
    logic                     valid;
    logic [ARCH_REG_BITS-1:0] arch_reg;
    PHYS_TAG                  phys_tag;
  } MAP_TABLE_WRITE_REQUEST;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    STORE_WAIT = 2'd1,
    FLUSH      = 2'd2,
    HALTED     = 2'd3
  } RETIRE_STATE;

  // Why the lane scan stopped where it did.
  typedef enum logic [2:0] {
    STOP_NONE        = 3'd0,
    STOP_NOT_READY   = 3'd1,
    STOP_STORE_WAIT  = 3'd2,
    STOP_STORE_BLOCK = 3'd3,
    STOP_MISPREDICT  = 3'd4,
    STOP_HALT        = 3'd5
  } STOP_REASON;

  function automatic logic [RC_W-1:0] popcount(input logic [N-1:0] m);
    logic [RC_W-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++) c = c + RC_W'(m[i]);
    return c;
  endfunction

endpackage

// File: rtl/stage_retire_if.sv
// Bundle of ROB-head inputs and retire outputs for stage_retire.
// Optional feature macro: RETIRE_PERF_CNT_EN (adds mispredict_count, stall_cycles).
interface stage_retire_if;
  import stage_retire_pkg::*;

  ROB_ENTRY [N-1:0]               rob_head_entries;
  logic [N-1:0]                   rob_head_uses_rd;
  logic [N-1:0]                   rob_head_is_store;
  logic [N-1:0]                   rob_head_mispredict;
  logic [N-1:0][31:0]             rob_head_target;
  logic [RC_W-1:0]                rob_retire_count;
  logic [N-1:0]                   free_valid;
  PHYS_TAG [N-1:0]                free_tag;
  MAP_TABLE_WRITE_REQUEST [N-1:0] archmap_write_reqs;
  logic                           sq_commit_req;
  logic                           sq_commit_ack;
  logic                           flush_valid;
  logic [31:0]                    flush_pc;
  logic                           halted;
  EXCEPTION_CODE                  halt_exception;
  logic [CNT_W-1:0]               retired_count;
`ifdef RETIRE_PERF_CNT_EN
  logic [CNT_W-1:0]               mispredict_count;
  logic [CNT_W-1:0]               stall_cycles;

  modport slave (
    input  rob_head_entries, rob_head_uses_rd, rob_head_is_store,
           rob_head_mispredict, rob_head_target, sq_commit_ack,
    output rob_retire_count, free_valid, free_tag, archmap_write_reqs,
           sq_commit_req, flush_valid, flush_pc, halted, halt_exception,
           retired_count, mispredict_count, stall_cycles
  );
  modport master (
    output rob_head_entries, rob_head_uses_rd, rob_head_is_store,
           rob_head_mispredict, rob_head_target, sq_commit_ack,
    input  rob_retire_count, free_valid, free_tag, archmap_write_reqs,
           sq_commit_req, flush_valid, flush_pc, halted, halt_exception,
           retired_count, mispredict_count, stall_cycles
  );
`else
  modport slave (
    input  rob_head_entries, rob_head_uses_rd, rob_head_is_store,
           rob_head_mispredict, rob_head_target, sq_commit_ack,
    output rob_retire_count, free_valid, free_tag, archmap_write_reqs,
           sq_commit_req, flush_valid, flush_pc, halted, halt_exception,
           retired_count
  );
  modport master (
    output rob_head_entries, rob_head_uses_rd, rob_head_is_store,
           rob_head_mispredict, rob_head_target, sq_commit_ack,
    input  rob_retire_count, free_valid, free_tag, archmap_write_reqs,
           sq_commit_req, flush_valid, flush_pc, halted, halt_exception,
           retired_count
  );
`endif

endinterface

// File: rtl/retire_select.sv
// Combinational in-order lane scan for the RUN state: which head lanes retire,
// why the scan stopped and at which lane, and whether the head store wants
// the store queue.
module retire_select
  import stage_retire_pkg::*;
(
  input  ROB_ENTRY [N-1:0] entries_i,
  input  logic [N-1:0]     is_store_i,
  input  logic [N-1:0]     mispredict_i,
  input  logic             sq_ack_i,
  output logic [N-1:0]     retire_mask_o,
  output STOP_REASON       stop_reason_o,
  output logic [LANE_W-1:0] stop_lane_o,
  output logic             store_req_o
);

  logic stopped;

  // Walk lanes oldest-first; the first lane that cannot retire (or that must
  // end the group) freezes the rest of the scan.
  always_comb begin
    retire_mask_o = '0;
    stop_reason_o = STOP_NONE;
    stop_lane_o   = '0;
    store_req_o   = 1'b0;
    stopped       = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!stopped) begin
        if (!(entries_i[i].valid && entries_i[i].complete)) begin
          stopped       = 1'b1;
          stop_reason_o = STOP_NOT_READY;
          stop_lane_o   = LANE_W'(i);
        end else if (entries_i[i].halt || (entries_i[i].exception != NO_ERROR)) begin
          // Halting/excepting entries retire without draining to the store queue.
          retire_mask_o[i] = 1'b1;
          stopped          = 1'b1;
          stop_reason_o    = STOP_HALT;
          stop_lane_o      = LANE_W'(i);
        end else if (is_store_i[i]) begin
          if (i == 0) begin
            store_req_o = 1'b1;
            if (sq_ack_i) begin
              retire_mask_o[i] = 1'b1;
            end else begin
              stopped       = 1'b1;
              stop_reason_o = STOP_STORE_WAIT;
              stop_lane_o   = LANE_W'(i);
            end
          end else begin
            // Only the head lane talks to the store queue.
            stopped       = 1'b1;
            stop_reason_o = STOP_STORE_BLOCK;
            stop_lane_o   = LANE_W'(i);
          end
        end else begin
          retire_mask_o[i] = 1'b1;
          if (entries_i[i].branch && mispredict_i[i]) begin
            stopped       = 1'b1;
            stop_reason_o = STOP_MISPREDICT;
            stop_lane_o   = LANE_W'(i);
          end
        end
      end
    end
  end

endmodule

// File: rtl/stage_retire.sv
// In-order commit stage at the ROB head: retires up to N complete entries per
// cycle, frees previous tags, writes the architectural map, drains stores via
// req/ack, flushes on mispredicts and stops on halt/exception.
// Optional feature macro: RETIRE_PERF_CNT_EN (mispredict_count, stall_cycles).
module stage_retire
  import stage_retire_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  stage_retire_if.slave rif
);

  RETIRE_STATE       state_q, state_d;
  logic [N-1:0]      sel_mask;
  STOP_REASON        sel_reason;
  logic [LANE_W-1:0] sel_lane;
  logic              sel_req;
  logic [N-1:0]      retire_mask;
  logic [RC_W-1:0]   retire_cnt;
  logic              flush_valid_q;
  logic [31:0]       flush_pc_q;
  logic              halted_q;
  EXCEPTION_CODE     halt_exception_q;
  logic [CNT_W-1:0]  retired_count_q;
  logic              enter_flush, enter_halt;

  retire_select u_select (
    .entries_i     (rif.rob_head_entries),
    .is_store_i    (rif.rob_head_is_store),
    .mispredict_i  (rif.rob_head_mispredict),
    .sq_ack_i      (rif.sq_commit_ack),
    .retire_mask_o (sel_mask),
    .stop_reason_o (sel_reason),
    .stop_lane_o   (sel_lane),
    .store_req_o   (sel_req)
  );

  // Next state and retire mask; everything is gated off while reset is high
  // so a pending store request drops without waiting for a clock.
  always_comb begin
    state_d           = state_q;
    retire_mask       = '0;
    rif.sq_commit_req = 1'b0;
    if (!reset) begin
      unique case (state_q)
        RUN: begin
          retire_mask       = sel_mask;
          rif.sq_commit_req = sel_req;
          if (sel_reason == STOP_HALT)            state_d = HALTED;
          else if (sel_reason == STOP_MISPREDICT) state_d = FLUSH;
          else if (sel_reason == STOP_STORE_WAIT) state_d = STORE_WAIT;
        end
        STORE_WAIT: begin
          rif.sq_commit_req = 1'b1;
          if (rif.sq_commit_ack) begin
            retire_mask = N'(1);
            state_d     = RUN;
          end
        end
        FLUSH:   state_d = RUN;
        HALTED:  state_d = HALTED;
        default: state_d = RUN;
      endcase
    end
  end

  assign retire_cnt  = popcount(retire_mask);
  assign enter_flush = (state_q == RUN) && (state_d == FLUSH);
  assign enter_halt  = (state_q == RUN) && (state_d == HALTED);

  // Per-lane freelist and map-table side effects; non-retired lanes stay zero.
  always_comb begin
    rif.free_valid         = '0;
    rif.free_tag           = '0;
    rif.archmap_write_reqs = '0;
    for (int i = 0; i < N; i++) begin
      if (retire_mask[i] && rif.rob_head_uses_rd[i]) begin
        rif.free_valid[i]                  = 1'b1;
        rif.free_tag[i]                    = rif.rob_head_entries[i].prev_phys_rd;
        rif.archmap_write_reqs[i].valid    = 1'b1;
        rif.archmap_write_reqs[i].arch_reg = rif.rob_head_entries[i].arch_rd;
        rif.archmap_write_reqs[i].phys_tag = rif.rob_head_entries[i].phys_rd;
      end
    end
  end

  // State register plus registered flush/halt/count outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q          <= RUN;
      flush_valid_q    <= 1'b0;
      flush_pc_q       <= '0;
      halted_q         <= 1'b0;
      halt_exception_q <= NO_ERROR;
      retired_count_q  <= '0;
    end else begin
      state_q         <= state_d;
      flush_valid_q   <= enter_flush;
      retired_count_q <= retired_count_q + CNT_W'(retire_cnt);
      if (enter_flush) flush_pc_q <= rif.rob_head_target[sel_lane];
      if (enter_halt) begin
        halted_q         <= 1'b1;
        halt_exception_q <= rif.rob_head_entries[sel_lane].exception;
      end
    end
  end

`ifdef RETIRE_PERF_CNT_EN
  logic [CNT_W-1:0] mispredict_count_q;
  logic [CNT_W-1:0] stall_cycles_q;

  // Counts retired mispredicts and head-valid cycles that retired nothing.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mispredict_count_q <= '0;
      stall_cycles_q     <= '0;
    end else begin
      if (enter_flush) mispredict_count_q <= mispredict_count_q + CNT_W'(1);
      if (((state_q == RUN) || (state_q == STORE_WAIT)) &&
          rif.rob_head_entries[0].valid && (retire_cnt == '0))
        stall_cycles_q <= stall_cycles_q + CNT_W'(1);
    end
  end

  assign rif.mispredict_count = mispredict_count_q;
  assign rif.stall_cycles     = stall_cycles_q;
`endif

  assign rif.rob_retire_count = retire_cnt;
  assign rif.flush_valid      = flush_valid_q;
  assign rif.flush_pc         = flush_pc_q;
  assign rif.halted           = halted_q;
  assign rif.halt_exception   = halt_exception_q;
  assign rif.retired_count    = retired_count_q;

endmodule

// File: tb/tb_stage_retire.sv
// Table-driven bench for stage_retire (N=3) plus hand sequences for
// reset-during-store-wait and exception halt.
module tb_stage_retire;
  import stage_retire_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  stage_retire_if rif ();

  stage_retire dut (
    .clock (clk),
    .reset (rst),
    .rif   (rif.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    ROB_ENTRY [2:0]      e;
    logic [2:0]          uses;
    logic [2:0]          st;
    logic [2:0]          mp;
    logic [2:0][31:0]    tgt;
    logic                ack;
    int                  ecnt;
    logic [2:0]          efree;
    PHYS_TAG [2:0]       etag;
    logic                ereq;
    logic                eflush;
    logic [31:0]         epc;
    logic                ehalt;
    longint              erc;
  } vec_t;

  vec_t vt[16];

  function automatic ROB_ENTRY mk(input logic v, input logic c, input int arch,
                                  input int prev, input EXCEPTION_CODE ex,
                                  input logic h, input logic br);
    ROB_ENTRY r;
    r.valid        = v;
    r.complete     = c;
    r.arch_rd      = ARCH_REG_BITS'(arch);
    r.prev_phys_rd = PHYS_TAG'(prev);
    r.phys_rd      = PHYS_TAG'(prev + 1);
    r.exception    = ex;
    r.halt         = h;
    r.branch       = br;
    return r;
  endfunction

  function automatic ROB_ENTRY alu(input int arch, input int prev);
    return mk(1'b1, 1'b1, arch, prev, NO_ERROR, 1'b0, 1'b0);
  endfunction

  function automatic vec_t row(input ROB_ENTRY l0, input ROB_ENTRY l1, input ROB_ENTRY l2,
                               input logic [2:0] uses, input logic [2:0] st,
                               input logic [2:0] mp, input logic ack, input int ecnt,
                               input logic [2:0] efree, input int t0, input int t1,
                               input int t2, input logic ereq, input logic eflush,
                               input logic [31:0] epc, input logic ehalt, input longint erc);
    vec_t v;
    v.e      = {l2, l1, l0};
    v.uses   = uses;
    v.st     = st;
    v.mp     = mp;
    v.tgt    = {32'h0000_2222, 32'h0000_1040, 32'h0000_1111};
    v.ack    = ack;
    v.ecnt   = ecnt;
    v.efree  = efree;
    v.etag   = {PHYS_TAG'(t2), PHYS_TAG'(t1), PHYS_TAG'(t0)};
    v.ereq   = ereq;
    v.eflush = eflush;
    v.epc    = epc;
    v.ehalt  = ehalt;
    v.erc    = erc;
    return v;
  endfunction

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", n, a, e);
    end
  endtask

  task automatic drive(input ROB_ENTRY [2:0] e, input logic [2:0] uses, input logic [2:0] st,
                       input logic [2:0] mp, input logic [2:0][31:0] tgt, input logic ack);
    rif.rob_head_entries    = e;
    rif.rob_head_uses_rd    = uses;
    rif.rob_head_is_store   = st;
    rif.rob_head_mispredict = mp;
    rif.rob_head_target     = tgt;
    rif.sq_commit_ack       = ack;
  endtask

  ROB_ENTRY EMP, STO, BR, HLT, INC, EXC;
  ROB_ENTRY [2:0] three_alu;
  MAP_TABLE_WRITE_REQUEST [2:0] emap;

  initial begin
    EMP = '0;
    STO = mk(1'b1, 1'b1, 0, 0, NO_ERROR, 1'b0, 1'b0);
    BR  = mk(1'b1, 1'b1, 0, 0, NO_ERROR, 1'b0, 1'b1);
    HLT = mk(1'b1, 1'b1, 0, 0, NO_ERROR, 1'b1, 1'b0);
    INC = mk(1'b1, 1'b0, 12, 50, NO_ERROR, 1'b0, 1'b0);
    EXC = mk(1'b1, 1'b1, 0, 0, ILLEGAL_INST, 1'b0, 1'b0);
    three_alu = {alu(3, 12), alu(2, 11), alu(1, 10)};

    //          lane0       lane1       lane2      uses    st      mp     ack cnt free  t0 t1 t2 req fl pc          h  rc
    vt[0]  = row(alu(1,10), alu(2,11), alu(3,12), 3'b111, 3'b000, 3'b000, 0, 3, 3'b111, 10,11,12, 0, 0, 32'h0,    0, 0);
    vt[1]  = row(EMP,       EMP,       EMP,       3'b000, 3'b000, 3'b000, 0, 0, 3'b000,  0, 0, 0, 0, 0, 32'h0,    0, 3);
    vt[2]  = row(alu(4,20), STO,       alu(6,22), 3'b101, 3'b010, 3'b000, 0, 1, 3'b001, 20, 0, 0, 0, 0, 32'h0,    0, 3);
    vt[3]  = row(STO,       alu(7,24), EMP,       3'b010, 3'b001, 3'b000, 0, 0, 3'b000,  0, 0, 0, 1, 0, 32'h0,    0, 4);
    vt[4]  = row(STO,       alu(7,24), EMP,       3'b010, 3'b001, 3'b000, 0, 0, 3'b000,  0, 0, 0, 1, 0, 32'h0,    0, 4);
    vt[5]  = row(STO,       alu(7,24), EMP,       3'b010, 3'b001, 3'b000, 1, 1, 3'b000,  0, 0, 0, 1, 0, 32'h0,    0, 4);
    vt[6]  = row(alu(8,30), BR,        alu(9,32), 3'b101, 3'b000, 3'b010, 0, 2, 3'b001, 30, 0, 0, 0, 0, 32'h0,    0, 5);
    vt[7]  = row(alu(8,30), BR,        alu(9,32), 3'b101, 3'b000, 3'b010, 0, 0, 3'b000,  0, 0, 0, 0, 1, 32'h1040, 0, 7);
    vt[8]  = row(EMP,       EMP,       EMP,       3'b000, 3'b000, 3'b000, 0, 0, 3'b000,  0, 0, 0, 0, 0, 32'h1040, 0, 7);
    vt[9]  = row(STO,       alu(10,40),INC,       3'b110, 3'b001, 3'b000, 1, 2, 3'b010,  0,40, 0, 1, 0, 32'h1040, 0, 7);
    vt[10] = row(HLT,       alu(11,41),EMP,       3'b010, 3'b000, 3'b000, 0, 1, 3'b000,  0, 0, 0, 0, 0, 32'h1040, 0, 9);
    for (int k = 11; k < 15; k++)
      vt[k] = row(alu(1,10), alu(2,11), alu(3,12), 3'b111, 3'b000, 3'b000, 0, 0, 3'b000, 0, 0, 0, 0, 0, 32'h1040, 1, 10);
    vt[15] = row(STO,       EMP,       EMP,       3'b000, 3'b001, 3'b000, 1, 0, 3'b000,  0, 0, 0, 0, 0, 32'h1040, 1, 10);

    // Reset state: inputs look retirable, but everything must read zero.
    drive(three_alu, 3'b111, 3'b001, 3'b000, '0, 1'b1);
    #2;
    chk("reset count", 64'(rif.rob_retire_count), 64'd0);
    chk("reset free_valid", 64'(rif.free_valid), 64'd0);
    chk("reset sq_req", 64'(rif.sq_commit_req), 64'd0);
    chk("reset flush", 64'(rif.flush_valid), 64'd0);
    chk("reset flush_pc", 64'(rif.flush_pc), 64'd0);
    chk("reset halted", 64'(rif.halted), 64'd0);
    chk("reset halt_exc", 64'(rif.halt_exception), 64'(NO_ERROR));
    chk("reset retired", 64'(rif.retired_count), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 16; k++) begin
      if (k != 0) @(negedge clk);
      drive(vt[k].e, vt[k].uses, vt[k].st, vt[k].mp, vt[k].tgt, vt[k].ack);
      #2;
      for (int i = 0; i < 3; i++)
        emap[i] = vt[k].efree[i] ? {1'b1, vt[k].e[i].arch_rd, vt[k].e[i].phys_rd} : '0;
      chk($sformatf("row%0d count", k), 64'(rif.rob_retire_count), 64'(vt[k].ecnt));
      chk($sformatf("row%0d free_valid", k), 64'(rif.free_valid), 64'(vt[k].efree));
      chk($sformatf("row%0d free_tag", k), 64'(rif.free_tag), 64'(vt[k].etag));
      chk($sformatf("row%0d archmap", k), 64'(rif.archmap_write_reqs), 64'(emap));
      chk($sformatf("row%0d sq_req", k), 64'(rif.sq_commit_req), 64'(vt[k].ereq));
      chk($sformatf("row%0d flush", k), 64'(rif.flush_valid), 64'(vt[k].eflush));
      chk($sformatf("row%0d flush_pc", k), 64'(rif.flush_pc), 64'(vt[k].epc));
      chk($sformatf("row%0d halted", k), 64'(rif.halted), 64'(vt[k].ehalt));
      chk($sformatf("row%0d halt_exc", k), 64'(rif.halt_exception), 64'(NO_ERROR));
      chk($sformatf("row%0d retired", k), 64'(rif.retired_count), 64'(vt[k].erc));
    end

    // Reset while waiting on a store ack.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive({EMP, EMP, STO}, 3'b000, 3'b001, 3'b000, '0, 1'b0);
    #2;
    chk("sw req before wait", 64'(rif.sq_commit_req), 64'd1);
    @(posedge clk);
    #1;
    chk("sw req held", 64'(rif.sq_commit_req), 64'd1);
    chk("sw count", 64'(rif.rob_retire_count), 64'd0);
    rst = 1'b1;
    #1;
    chk("sw req async drop", 64'(rif.sq_commit_req), 64'd0);
    rif.sq_commit_ack = 1'b1;
    #1;
    chk("sw late ack count", 64'(rif.rob_retire_count), 64'd0);
    chk("sw retired cleared", 64'(rif.retired_count), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(three_alu, 3'b111, 3'b000, 3'b000, '0, 1'b0);
    #2;
    chk("post-reset RUN count", 64'(rif.rob_retire_count), 64'd3);
    chk("post-reset retired", 64'(rif.retired_count), 64'd0);
    chk("post-reset halted", 64'(rif.halted), 64'd0);

    // Exception at the head halts with its code latched.
    @(negedge clk);
    drive({EMP, alu(5, 33), EXC}, 3'b010, 3'b000, 3'b000, '0, 1'b0);
    #2;
    chk("exc count", 64'(rif.rob_retire_count), 64'd1);
    chk("exc retired before", 64'(rif.retired_count), 64'd3);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive(three_alu, 3'b111, 3'b000, 3'b000, '0, 1'b0);
      #2;
      chk($sformatf("exc halted c%0d", c), 64'(rif.halted), 64'd1);
      chk($sformatf("exc code c%0d", c), 64'(rif.halt_exception), 64'(ILLEGAL_INST));
      chk($sformatf("exc count c%0d", c), 64'(rif.rob_retire_count), 64'd0);
      chk($sformatf("exc retired c%0d", c), 64'(rif.retired_count), 64'd4);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stage_retire.md
Name: stage_retire

Overview:
- In-order commit stage at the ROB head; the release end of dispatch's allocation.
- Each cycle it retires up to N complete head entries in order. For each retired destination it frees the previous physical tag to the freelist and writes the architectural map.
- Drains stores to the store queue through a req/ack handshake.
- Raises a registered flush on mispredicted branches and stops permanently on halt or exception.

Parameters:
- N, `N, retire width (lanes).
- PHYS_TAG_BITS, `PHYS_TAG_BITS, physical tag width.
- ARCH_REG_BITS, 5, architectural register index width.
- CNT_W, 64, width of the retired-instruction counter.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- rob_head_entries  in  N x ROB_ENTRY  oldest-first ROB head. Lane 0 is the head. Fields used: valid, complete, arch_rd, phys_rd, prev_phys_rd, exception, halt, branch.
- rob_head_uses_rd  in  N  lane writes a destination register.
- rob_head_is_store  in  N  lane is a store.
- rob_head_mispredict  in  N  resolved branch was mispredicted.
- rob_head_target  in  N x 32  correct next PC of the lane.
- rob_retire_count  out  $clog2(N+1)  entries the ROB pops this cycle.
- free_valid  out  N  return prev_phys_rd to the freelist.
- free_tag  out  N x PHYS_TAG_BITS  tag being freed.
- archmap_write_reqs  out  N x MAP_TABLE_WRITE_REQUEST  arch_rd→phys_rd. Lane order; a later lane wins.
- sq_commit_req  out  1  request commit of the store-queue head.
- sq_commit_ack  in  1  store committed this cycle.
- flush_valid  out  1  one-cycle flush pulse (registered).
- flush_pc  out  32  redirect PC (registered).
- halted  out  1  sticky; processor stopped.
- halt_exception  out  EXCEPTION_CODE  exception code of the halting entry (NO_ERROR for a plain halt).
- retired_count  out  CNT_W  total retired instructions.

Behaviour:
- States: RUN, STORE_WAIT, FLUSH, HALTED. Reset enters RUN.
- Reset values: all outputs 0, halt_exception=NO_ERROR.
- Retire outputs (rob_retire_count, free_*, archmap_*, sq_commit_req) are combinational from state and inputs. flush_*, halted, halt_exception and retired_count are registered.
- RUN scan, lanes 0..N-1 in order; stop at the first lane that is not valid&&complete.
  - Lane 0 store: assert sq_commit_req.
    - If sq_commit_ack is high the same cycle, retire it and continue scanning.
    - Otherwise retire nothing and go to STORE_WAIT.
  - Store in lane i>0: stop before it. Stores retire only from lane 0, at most one per cycle.
  - Mispredicted branch: retire it and stop. Next state FLUSH. Next cycle flush_valid=1 and flush_pc=rob_head_target of that lane.
  - halt=1 or exception!=NO_ERROR: retire it and stop. Next state HALTED; halted=1 and halt_exception latched.
- Per retired lane with uses_rd: free_valid=1, free_tag=prev_phys_rd, archmap write valid.
- Non-retired lanes drive all outputs 0.
- STORE_WAIT:
  - Hold sq_commit_req=1; retire nothing until ack.
  - On ack: retire lane 0 (count 1), then return to RUN.
  - The head cannot change while in this state.
- FLUSH: flush_valid=1 for exactly one cycle; retire nothing; next state RUN. The ROB is cleared by the flush; no entries retire in the flush cycle.
- HALTED: absorbing; retire nothing; sq_commit_req=0. Only reset exits.
- retired_count += rob_retire_count every cycle. Wraps modulo 2^CNT_W.
- Empty ROB (lane 0 invalid): count 0, no side effects.
- Reset asserted mid-STORE_WAIT: sq_commit_req drops immediately (asynchronous). A late ack is ignored.

Optional Feature:
- RETIRE_PERF_CNT_EN defined: adds outputs mispredict_count (CNT_W) and stall_cycles (CNT_W).
  - mispredict_count: +1 per retired mispredicted branch.
  - stall_cycles: +1 per cycle in RUN or STORE_WAIT with lane 0 valid and rob_retire_count==0.
  - Both reset to 0.
- Undefined: the ports and counters do not exist. Retire behaviour is identical.

Decomposition:
- sys_defs.svh holds ROB_ENTRY, MAP_TABLE_WRITE_REQUEST, PHYS_TAG, EXCEPTION_CODE and `N. Add RETIRE_STATE enum {RUN, STORE_WAIT, FLUSH, HALTED} there.
- One sub-module, retire_select: combinational lane scan producing the retire mask, stop reason and stop lane. The parent holds the FSM and registers.

Test Plan:
- 3 complete ALU entries with uses_rd (prev tags 10,11,12), N=3 → count 3; free_tag={10,11,12}; retired_count 0→3 next cycle.
- Lanes: ALU complete, store complete, ALU complete → cycle 1 count 1. Next cycle store at lane 0 with no ack → STORE_WAIT, req held. Ack two cycles later → count 1, back to RUN.
- Mispredicted branch in lane 1, target 0x1040 → count 2 (lane 2 not retired). Next cycle flush_valid=1 with flush_pc=0x1040 for one cycle only.
- Halt in lane 0 with lane 1 complete → count 1; halted=1 next cycle; count stays 0 for 5 more cycles.
- Exception entry (illegal instruction) in lane 0 → halted=1 and halt_exception=illegal instruction next cycle; count stays 0 afterwards.
- Reset asserted in STORE_WAIT → sq_commit_req=0 without waiting for a clock edge; state RUN and retired_count=0 after release.
